coin_pulse_gen: RTL and testbench

COIN_PULSE_GEN -- requirements
Module: coin_pulse_gen

---
 rtl/coin_pulse_gen.sv | 183 ++++++++++++++++++
 tb/tb_coin_pulse_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_pulse_gen.sv
// Coin input front end: synchronizes and debounces two coin switches, emits
// one-cycle coin pulses, and rejects coins during a post-dispense lockout.
module coin_pulse_gen #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [15:0] LOCK_MAX = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_one,
    input  logic       key_half,
    input  logic       pi_cola,
    output logic       po_money_one,
    output logic       po_money_half,
    output logic       po_lock,
    output logic [7:0] po_reject_cnt
);

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned LOCK_W = 16;
    localparam int unsigned REJ_W  = 8;
    localparam int unsigned ADD_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_LOCK = 2'b10
    } state_e;

    logic [1:0]        one_sync_q;
    logic [1:0]        half_sync_q;
    logic [CNT_W-1:0]  one_cnt_q;
    logic [CNT_W-1:0]  one_cnt_d;
    logic [CNT_W-1:0]  half_cnt_q;
    logic [CNT_W-1:0]  half_cnt_d;
    logic              one_qual_c;
    logic              half_qual_c;

    state_e            state_q;
    state_e            state_d;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic [LOCK_W-1:0] lock_cnt_d;
    logic              locked_c;

    logic              money_one_q;
    logic              money_one_d;
    logic              money_half_q;
    logic              money_half_d;
    logic              pending_half_q;
    logic              pending_half_d;
    logic              lock_q;
    logic [REJ_W-1:0]  reject_q;
    logic [REJ_W-1:0]  reject_d;
    logic [ADD_W-1:0]  reject_add;
    logic [REJ_W:0]    reject_sum;

    // Two-flop synchronizers; idle level of an active-low switch is 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            one_sync_q  <= 2'b11;
            half_sync_q <= 2'b11;
        end else begin
            one_sync_q  <= {one_sync_q[0], key_one};
            half_sync_q <= {half_sync_q[0], key_half};
        end
    end

    // Debounce counters: clear on release, count while held, park at CNT_MAX.
    always_comb begin
        one_cnt_d  = one_cnt_q;
        half_cnt_d = half_cnt_q;
        if (one_sync_q[1]) begin
            one_cnt_d = '0;
        end else if (one_cnt_q != CNT_MAX) begin
            one_cnt_d = one_cnt_q + CNT_W'(1);
        end
        if (half_sync_q[1]) begin
            half_cnt_d = '0;
        end else if (half_cnt_q != CNT_MAX) begin
            half_cnt_d = half_cnt_q + CNT_W'(1);
        end
    end

    assign one_qual_c  = !one_sync_q[1]  && (one_cnt_q  == CNT_MAX - CNT_W'(1));
    assign half_qual_c = !half_sync_q[1] && (half_cnt_q == CNT_MAX - CNT_W'(1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            one_cnt_q  <= '0;
            half_cnt_q <= '0;
        end else begin
            one_cnt_q  <= one_cnt_d;
            half_cnt_q <= half_cnt_d;
        end
    end

    // Lockout FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Lockout FSM next state; a new dispense always restarts the window.
    always_comb begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pi_cola) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (pi_cola) begin
                    state_d = ST_LOCK;
                end else if (lock_cnt_q == LOCK_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_LOCK;
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A coin is rejected only if the lockout holds across its qualifying cycle.
    assign locked_c = (state_q == ST_LOCK) && (state_d == ST_LOCK);

    // Coin acceptance, half-coin deferral and reject counting.
    always_comb begin
        money_one_d    = 1'b0;
        money_half_d   = 1'b0;
        pending_half_d = pending_half_q;
        reject_add     = '0;
        reject_sum     = {1'b0, reject_q};
        reject_d       = reject_q;
        if (locked_c) begin
            reject_add     = ADD_W'(one_qual_c) + ADD_W'(half_qual_c)
                           + ADD_W'(pending_half_q);
            reject_sum     = {1'b0, reject_q} + (REJ_W + 1)'(reject_add);
            reject_d       = reject_sum[REJ_W] ? {REJ_W{1'b1}} : reject_sum[REJ_W-1:0];
            pending_half_d = 1'b0;
        end else if (one_qual_c) begin
            money_one_d = 1'b1;
            if (half_qual_c && !pending_half_q) begin
                pending_half_d = 1'b1;
            end
        end else if (pending_half_q) begin
            money_half_d   = 1'b1;
            pending_half_d = 1'b0;
        end else begin
            money_half_d = half_qual_c;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            money_one_q    <= 1'b0;
            money_half_q   <= 1'b0;
            pending_half_q <= 1'b0;
            lock_q         <= 1'b0;
            reject_q       <= '0;
        end else begin
            money_one_q    <= money_one_d;
            money_half_q   <= money_half_d;
            pending_half_q <= pending_half_d;
            lock_q         <= (state_d == ST_LOCK);
            reject_q       <= reject_d;
        end
    end

    assign po_money_one  = money_one_q;
    assign po_money_half = money_half_q;
    assign po_lock       = lock_q;
    assign po_reject_cnt = reject_q;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Self-checking bench for coin_pulse_gen with CNT_MAX=4, LOCK_MAX=8:
// directed scenarios plus randomized traffic against a run-length reference model.
module tb_coin_pulse_gen;

    localparam int TB_CNT  = 4;
    localparam int TB_LOCK = 8;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_one;
    logic       key_half;
    logic       pi_cola;
    logic       po_money_one;
    logic       po_money_half;
    logic       po_lock;
    logic [7:0] po_reject_cnt;

    int total = 0;
    int bad   = 0;

    coin_pulse_gen #(
        .CNT_MAX (20'd4),
        .LOCK_MAX(16'd8)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_one      (key_one),
        .key_half     (key_half),
        .pi_cola      (pi_cola),
        .po_money_one (po_money_one),
        .po_money_half(po_money_half),
        .po_lock      (po_lock),
        .po_reject_cnt(po_reject_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Reference: a key qualifies when its raw low run, seen two samples late,
    // is exactly TB_CNT long; lockout spans TB_LOCK+1 cycles after the last dispense.
    int m_run1, m_old1, m_run2, m_old2, m_since, m_rej;
    bit m_one, m_half, m_lock, m_pend;

    always @(posedge sys_clk or negedge sys_rst_n) begin : ref_model
        bit q1, q2, lk_now, blocked, one, half, nxt_pend;
        int since, rej;
        if (!sys_rst_n) begin
            m_run1 <= 0; m_old1 <= 0; m_run2 <= 0; m_old2 <= 0;
            m_since <= 1000; m_rej <= 0;
            m_one <= 0; m_half <= 0; m_lock <= 0; m_pend <= 0;
        end else begin
            q1       = (m_old1 == TB_CNT);
            q2       = (m_old2 == TB_CNT);
            since    = pi_cola ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
            lk_now   = (since <= TB_LOCK);
            blocked  = m_lock && lk_now;
            one      = 1'b0;
            half     = 1'b0;
            nxt_pend = m_pend;
            rej      = m_rej;
            if (blocked) begin
                rej = m_rej + int'(q1) + int'(q2) + int'(m_pend);
                if (rej > 255) rej = 255;
                nxt_pend = 1'b0;
            end else if (q1) begin
                one = 1'b1;
                if (q2 && !m_pend) nxt_pend = 1'b1;
            end else if (m_pend) begin
                half     = 1'b1;
                nxt_pend = 1'b0;
            end else begin
                half = q2;
            end
            m_old1  <= m_run1;
            m_run1  <= key_one  ? 0 : ((m_run1 < 1000) ? m_run1 + 1 : m_run1);
            m_old2  <= m_run2;
            m_run2  <= key_half ? 0 : ((m_run2 < 1000) ? m_run2 + 1 : m_run2);
            m_since <= since;
            m_lock  <= lk_now;
            m_one   <= one;
            m_half  <= half;
            m_pend  <= nxt_pend;
            m_rej   <= rej;
        end
    end

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        key_one   = 1'b1;
        key_half  = 1'b1;
        pi_cola   = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        #3 sys_rst_n = 1'b0;
        #1;
        total++; if (po_money_one !== 1'b0) begin bad++; $display("FAIL reset_one got=%b want=0", po_money_one); end
        total++; if (po_money_half !== 1'b0) begin bad++; $display("FAIL reset_half got=%b want=0", po_money_half); end
        total++; if (po_lock !== 1'b0) begin bad++; $display("FAIL reset_lock got=%b want=0", po_lock); end
        total++; if (po_reject_cnt !== 8'h00) begin bad++; $display("FAIL reset_rej got=%h want=00", po_reject_cnt); end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge sys_clk);
            total++;
            if ({po_money_one, po_money_half, po_lock, po_reject_cnt} !== 11'd0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d got=%b%b%b/%h want=000/00", i,
                         po_money_one, po_money_half, po_lock, po_reject_cnt);
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            key_one = (i == 2) || (i > 11);
            @(negedge sys_clk);
            total++; if (po_money_one !== 1'(i == 8)) begin bad++; $display("FAIL bounce_one cycle %0d got=%b want=%b", i, po_money_one, (i == 8)); end
            total++; if (po_money_half !== 1'b0) begin bad++; $display("FAIL bounce_half cycle %0d got=%b want=0", i, po_money_half); end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 1; i <= 14; i++) begin
            key_one  = (i > 10);
            key_half = (i > 10);
            @(negedge sys_clk);
            total++; if (po_money_one !== 1'(i == 6)) begin bad++; $display("FAIL simul_one cycle %0d got=%b want=%b", i, po_money_one, (i == 6)); end
            total++; if (po_money_half !== 1'(i == 7)) begin bad++; $display("FAIL simul_half cycle %0d got=%b want=%b", i, po_money_half, (i == 7)); end
        end
    endtask

    task automatic test_lock_reject();
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            pi_cola  = (i == 1);
            key_half = !(i >= 2 && i <= 11);
            @(negedge sys_clk);
            total++; if (po_lock !== 1'(i <= 9)) begin bad++; $display("FAIL lockrej_lock cycle %0d got=%b want=%b", i, po_lock, (i <= 9)); end
            total++; if (po_money_half !== 1'b0) begin bad++; $display("FAIL lockrej_half cycle %0d got=%b want=0", i, po_money_half); end
        end
        total++; if (po_reject_cnt !== 8'd1) begin bad++; $display("FAIL lockrej_cnt got=%0d want=1", po_reject_cnt); end
    endtask

    task automatic test_lock_restart();
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            pi_cola = (i == 1) || (i == 7);
            @(negedge sys_clk);
            total++; if (po_lock !== 1'(i <= 15)) begin bad++; $display("FAIL restart_lock cycle %0d got=%b want=%b", i, po_lock, (i <= 15)); end
        end
    endtask

    task automatic test_cola_same_cycle();
        apply_reset();
        for (int i = 1; i <= 18; i++) begin
            key_one = !(i >= 1 && i <= 8);
            pi_cola = (i == 6);
            @(negedge sys_clk);
            total++; if (po_money_one !== 1'(i == 6)) begin bad++; $display("FAIL cola_one cycle %0d got=%b want=%b", i, po_money_one, (i == 6)); end
            total++; if (po_lock !== 1'(i >= 6 && i <= 14)) begin bad++; $display("FAIL cola_lock cycle %0d got=%b want=%b", i, po_lock, (i >= 6 && i <= 14)); end
        end
        total++; if (po_reject_cnt !== 8'd0) begin bad++; $display("FAIL cola_rej got=%0d want=0", po_reject_cnt); end
    endtask

    task automatic test_lock_exit_boundary();
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            pi_cola  = (i == 1);
            key_half = !(i >= 4 && i <= 11);
            key_one  = !(i >= 5 && i <= 12);
            @(negedge sys_clk);
            total++; if (po_money_one !== 1'(i == 10)) begin bad++; $display("FAIL exit_one cycle %0d got=%b want=%b", i, po_money_one, (i == 10)); end
            total++; if (po_money_half !== 1'b0) begin bad++; $display("FAIL exit_half cycle %0d got=%b want=0", i, po_money_half); end
        end
        total++; if (po_reject_cnt !== 8'd1) begin bad++; $display("FAIL exit_rej got=%0d want=1", po_reject_cnt); end
    endtask

    task automatic test_reset_mid_press();
        apply_reset();
        key_one = 1'b0;
        repeat (5) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        total++;
        if ({po_money_one, po_money_half, po_lock, po_reject_cnt} !== 11'd0) begin
            bad++;
            $display("FAIL midrst_async got=%b%b%b/%h want=000/00", po_money_one, po_money_half, po_lock, po_reject_cnt);
        end
        repeat (3) begin
            @(negedge sys_clk);
            total++;
            if ({po_money_one, po_money_half, po_lock, po_reject_cnt} !== 11'd0) begin
                bad++;
                $display("FAIL midrst_hold got=%b%b%b/%h want=000/00", po_money_one, po_money_half, po_lock, po_reject_cnt);
            end
        end
        sys_rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge sys_clk);
            total++; if (po_money_one !== 1'(i == 6)) begin bad++; $display("FAIL midrst_one cycle %0d got=%b want=%b", i, po_money_one, (i == 6)); end
        end
        key_one = 1'b1;
    endtask

    task automatic test_reject_saturation();
        int want;
        apply_reset();
        pi_cola = 1'b1;
        repeat (2) @(negedge sys_clk);
        for (int n = 1; n <= 150; n++) begin
            key_one  = 1'b0;
            key_half = 1'b0;
            repeat (6) @(negedge sys_clk);
            key_one  = 1'b1;
            key_half = 1'b1;
            repeat (2) @(negedge sys_clk);
            want = (2 * n > 255) ? 255 : 2 * n;
            total++; if (po_reject_cnt !== 8'(want)) begin bad++; $display("FAIL sat_cnt press %0d got=%0d want=%0d", n, po_reject_cnt, want); end
        end
        total++; if ({po_money_one, po_money_half, po_lock} !== 3'b001) begin bad++; $display("FAIL sat_outs got=%b%b%b want=001", po_money_one, po_money_half, po_lock); end
        pi_cola = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) key_one  = ~key_one;
            if ($urandom_range(5) == 0) key_half = ~key_half;
            pi_cola = ($urandom_range(59) == 0);
            @(negedge sys_clk);
            total++; if (po_money_one !== m_one) begin bad++; $display("FAIL rand_one cycle %0d got=%b want=%b", c, po_money_one, m_one); end
            total++; if (po_money_half !== m_half) begin bad++; $display("FAIL rand_half cycle %0d got=%b want=%b", c, po_money_half, m_half); end
            total++; if (po_lock !== m_lock) begin bad++; $display("FAIL rand_lock cycle %0d got=%b want=%b", c, po_lock, m_lock); end
            total++; if (po_reject_cnt !== 8'(m_rej)) begin bad++; $display("FAIL rand_rej cycle %0d got=%0d want=%0d", c, po_reject_cnt, m_rej); end
        end
    endtask

    initial begin
        sys_rst_n = 1'b1;
        key_one   = 1'b1;
        key_half  = 1'b1;
        pi_cola   = 1'b0;
        test_reset();
        test_bounce();
        test_simultaneous();
        test_lock_reject();
        test_lock_restart();
        test_cola_same_cycle();
        test_lock_exit_boundary();
        test_reset_mid_press();
        test_reject_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
